// File: rtl/ann_io_frontend_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ann_io_frontend_if
// Description : Host pin bundle between the host and the accelerator front
//               end: load/word stream, start, done flag and output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface ann_io_frontend_if #(
   parameter int DATA_WIDTH = 11
);
   logic                  load_kdtree;
   logic                  in_wenq;
   logic [DATA_WIDTH-1:0] in_wdata;
   logic                  fsm_start;
   logic                  send_best_arr;
   logic                  out_deq;
   logic [DATA_WIDTH-1:0] out_rdata;
   logic                  out_rempty_n;
   logic                  fsm_done;

   // Host side drives commands and the input stream
   modport master (
      output load_kdtree, in_wenq, in_wdata, fsm_start, send_best_arr, out_deq,
      input  out_rdata, out_rempty_n, fsm_done
   );

   // Accelerator side responds
   modport slave (
      input  load_kdtree, in_wenq, in_wdata, fsm_start, send_best_arr, out_deq,
      output out_rdata, out_rempty_n, fsm_done
   );
endinterface
`default_nettype wire

// File: rtl/ann_io_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ann_io_frontend
// Description : Accelerator-side responder for the host pin protocol. Routes
//               the load word stream to node/leaf/query write ports, starts
//               the core, then drains the result memory in host order through
//               a 2-entry output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module ann_io_frontend #(
   parameter  int DATA_WIDTH  = 11,
   parameter  int NUM_LEAVES  = 64,
   parameter  int ROW_SIZE    = 26,
   parameter  int COL_SIZE    = 19,
   parameter  int BLOCKING    = 4,
   localparam int NUM_NODES   = NUM_LEAVES - 1,
   localparam int NUM_QUERYS  = ROW_SIZE * COL_SIZE,
   localparam int NODE_AW     = $clog2(NUM_NODES),
   localparam int LEAF_AW     = $clog2(NUM_LEAVES * 48),
   localparam int QUERY_AW    = $clog2(NUM_QUERYS * 5),
   localparam int RES_AW      = $clog2(NUM_QUERYS)
) (
   input  logic                    io_clk,
   input  logic                    io_rst_n,
   ann_io_frontend_if.slave        host,
   output logic                    node_wen,
   output logic [NODE_AW-1:0]      node_waddr,
   output logic [2*DATA_WIDTH-1:0] node_wdata,
   output logic                    leaf_wen,
   output logic [LEAF_AW-1:0]      leaf_waddr,
   output logic [DATA_WIDTH-1:0]   leaf_wdata,
   output logic                    query_wen,
   output logic [QUERY_AW-1:0]     query_waddr,
   output logic [DATA_WIDTH-1:0]   query_wdata,
   output logic                    core_start,
   input  logic                    core_done,
   output logic                    res_ren,
   output logic [RES_AW-1:0]       res_raddr,
   input  logic [DATA_WIDTH-1:0]   res_rdata
);

   localparam int NODE_WORDS  = NUM_NODES * 2;
   localparam int LEAF_WORDS  = NUM_LEAVES * 48;
   localparam int QUERY_WORDS = NUM_QUERYS * 5;
   localparam int MAX_WORDS   = (LEAF_WORDS > QUERY_WORDS) ?
                                ((LEAF_WORDS > NODE_WORDS) ? LEAF_WORDS : NODE_WORDS) :
                                ((QUERY_WORDS > NODE_WORDS) ? QUERY_WORDS : NODE_WORDS);
   localparam int CNT_W       = $clog2(MAX_WORDS);
   localparam int HALF_ROW    = ROW_SIZE / 2;
   localparam int XB          = (HALF_ROW + BLOCKING - 1) / BLOCKING;
   localparam int X_W         = (XB > 1) ? $clog2(XB) : 1;
   localparam int Y_W         = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
   localparam int XI_W        = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
   localparam int ISS_W       = $clog2(NUM_QUERYS + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LD_NODE  = 3'd1,
      S_LD_LEAF  = 3'd2,
      S_LD_QUERY = 3'd3,
      S_READY    = 3'd4,
      S_RUN      = 3'd5,
      S_DONE     = 3'd6,
      S_SEND     = 3'd7
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] idx_q, idx_d;
   logic                  core_start_q, core_start_d;
   logic                  fsm_done_q, fsm_done_d;
   logic                  px_q, px_d;
   logic [X_W-1:0]        x_q, x_d;
   logic [Y_W-1:0]        y_q, y_d;
   logic [XI_W-1:0]       xi_q, xi_d;
   logic [ISS_W-1:0]      iss_q, iss_d;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic [DATA_WIDTH-1:0] fifo_d [2];
   logic                  wp_q, wp_d;
   logic                  rp_q, rp_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;

   logic                  w_load;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_iss_done;
   logic [2:0]            w_slots;
   logic                  w_ren;
   logic [RES_AW-1:0]     w_col;
   logic [RES_AW-1:0]     w_addr;
   logic                  w_last_xi;
   logic                  w_last_pop;

   // Handshake qualifiers, drain address and buffer-credit arithmetic
   always_comb begin
      w_load     = host.load_kdtree;
      w_accept   = host.in_wenq && !w_load;
      w_push     = inflight_q;
      w_pop      = host.out_deq && (occ_q != 2'd0);
      w_iss_done = (iss_q == ISS_W'(NUM_QUERYS));
      // A read may issue only if its data will find a free buffer slot
      w_slots    = 3'(occ_q) + 3'(inflight_q) - 3'(w_pop);
      w_ren      = (state_q == S_SEND) && !w_load && !w_iss_done && (w_slots < 3'd2);
      w_col      = RES_AW'(x_q) * RES_AW'(BLOCKING) + RES_AW'(xi_q);
      w_addr     = RES_AW'(px_q) * RES_AW'(HALF_ROW) + RES_AW'(y_q) * RES_AW'(ROW_SIZE) + w_col;
      // Columns past the half-row end are skipped by wrapping xi early
      w_last_xi  = (xi_q == XI_W'(BLOCKING - 1)) ||
                   ((w_col + RES_AW'(1)) >= RES_AW'(HALF_ROW));
      w_last_pop = (state_q == S_SEND) && w_pop && w_iss_done && !inflight_q &&
                   (occ_q == 2'd1);
   end

   // Next-state logic for the protocol FSM, load counter, drain iterator and buffer
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      core_start_d = 1'b0;
      fsm_done_d   = fsm_done_q;
      px_d         = px_q;
      x_d          = x_q;
      y_d          = y_q;
      xi_d         = xi_q;
      iss_d        = iss_q;
      fifo_d       = fifo_q;
      wp_d         = wp_q;
      rp_d         = rp_q;
      occ_d        = occ_q;
      inflight_d   = w_ren;

      case (state_q)
         S_LD_NODE: begin
            if (w_accept) begin
               // Even word is the split index; held until its median arrives
               if (!cnt_q[0]) idx_d = host.in_wdata;
               if (cnt_q == CNT_W'(NODE_WORDS - 1)) begin
                  cnt_d   = '0;
                  state_d = S_LD_LEAF;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LD_LEAF: begin
            if (w_accept) begin
               if (cnt_q == CNT_W'(LEAF_WORDS - 1)) begin
                  cnt_d   = '0;
                  state_d = S_LD_QUERY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LD_QUERY: begin
            if (w_accept) begin
               if (cnt_q == CNT_W'(QUERY_WORDS - 1)) begin
                  cnt_d   = '0;
                  state_d = S_READY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_READY: begin
            if (host.fsm_start) begin
               core_start_d = 1'b1;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            if (core_done) begin
               fsm_done_d = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            if (host.send_best_arr) begin
               px_d    = 1'b0;
               x_d     = '0;
               y_d     = '0;
               xi_d    = '0;
               iss_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (w_ren) begin
               iss_d = iss_q + 1'b1;
               if (w_last_xi) begin
                  xi_d = '0;
                  if (y_q == Y_W'(COL_SIZE - 1)) begin
                     y_d = '0;
                     if (x_q == X_W'(XB - 1)) begin
                        x_d  = '0;
                        px_d = ~px_q;
                     end else begin
                        x_d = x_q + 1'b1;
                     end
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end else begin
                  xi_d = xi_q + 1'b1;
               end
            end
            if (w_last_pop) state_d = S_IDLE;
         end
         default: ;
      endcase

      if (w_push) begin
         fifo_d[wp_q] = res_rdata;
         wp_d         = ~wp_q;
      end
      if (w_pop) rp_d = ~rp_q;
      occ_d = occ_q + {1'b0, w_push} - {1'b0, w_pop};

      // A new load sequence wins over everything else in any state
      if (w_load) begin
         state_d      = S_LD_NODE;
         cnt_d        = '0;
         core_start_d = 1'b0;
         fsm_done_d   = 1'b0;
         px_d         = 1'b0;
         x_d          = '0;
         y_d          = '0;
         xi_d         = '0;
         iss_d        = '0;
         wp_d         = 1'b0;
         rp_d         = 1'b0;
         occ_d        = 2'd0;
         inflight_d   = 1'b0;
      end
   end

   // State register bank
   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         core_start_q <= 1'b0;
         fsm_done_q   <= 1'b0;
         px_q         <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         xi_q         <= '0;
         iss_q        <= '0;
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
         wp_q         <= 1'b0;
         rp_q         <= 1'b0;
         occ_q        <= 2'd0;
         inflight_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         core_start_q <= core_start_d;
         fsm_done_q   <= fsm_done_d;
         px_q         <= px_d;
         x_q          <= x_d;
         y_q          <= y_d;
         xi_q         <= xi_d;
         iss_q        <= iss_d;
         fifo_q[0]    <= fifo_d[0];
         fifo_q[1]    <= fifo_d[1];
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         occ_q        <= occ_d;
         inflight_q   <= inflight_d;
      end
   end

   // Write strobes follow the accepted word combinationally; idle buses read 0
   always_comb begin
      node_wen          = w_accept && (state_q == S_LD_NODE) && cnt_q[0];
      node_waddr        = node_wen ? cnt_q[NODE_AW:1] : '0;
      node_wdata        = node_wen ? {idx_q, host.in_wdata} : '0;
      leaf_wen          = w_accept && (state_q == S_LD_LEAF);
      leaf_waddr        = leaf_wen ? cnt_q[LEAF_AW-1:0] : '0;
      leaf_wdata        = leaf_wen ? host.in_wdata : '0;
      query_wen         = w_accept && (state_q == S_LD_QUERY);
      query_waddr       = query_wen ? cnt_q[QUERY_AW-1:0] : '0;
      query_wdata       = query_wen ? host.in_wdata : '0;
      core_start        = core_start_q;
      res_ren           = w_ren;
      res_raddr         = w_ren ? w_addr : '0;
      host.out_rempty_n = (occ_q != 2'd0);
      host.out_rdata    = (occ_q != 2'd0) ? fifo_q[rp_q] : '0;
      host.fsm_done     = fsm_done_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_ann_io_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ann_io_frontend
// Description : Self-checking bench for ann_io_frontend. Stimulus pushes
//               expected writes/words into queues; a negedge monitor pops and
//               compares whenever the DUT strobes or presents output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ann_io_frontend;
   localparam int DW          = 11;
   localparam int NQ          = 494;
   localparam int NODE_WORDS  = 126;
   localparam int LEAF_WORDS  = 3072;
   localparam int QUERY_WORDS = 2470;
   localparam int TOTAL       = NODE_WORDS + LEAF_WORDS + QUERY_WORDS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ann_io_frontend_if #(.DATA_WIDTH(DW)) host ();

   logic          node_wen;
   logic [5:0]    node_waddr;
   logic [21:0]   node_wdata;
   logic          leaf_wen;
   logic [11:0]   leaf_waddr;
   logic [10:0]   leaf_wdata;
   logic          query_wen;
   logic [11:0]   query_waddr;
   logic [10:0]   query_wdata;
   logic          core_start;
   logic          core_done;
   logic          res_ren;
   logic [8:0]    res_raddr;
   logic [10:0]   res_rdata;

   ann_io_frontend #(
      .DATA_WIDTH(DW), .NUM_LEAVES(64), .ROW_SIZE(26), .COL_SIZE(19), .BLOCKING(4)
   ) dut (
      .io_clk(clk), .io_rst_n(rst_n), .host(host),
      .node_wen(node_wen), .node_waddr(node_waddr), .node_wdata(node_wdata),
      .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wdata(leaf_wdata),
      .query_wen(query_wen), .query_waddr(query_waddr), .query_wdata(query_wdata),
      .core_start(core_start), .core_done(core_done),
      .res_ren(res_ren), .res_raddr(res_raddr), .res_rdata(res_rdata)
   );

   typedef struct {int addr; int data;} wr_t;
   wr_t node_q[$];
   wr_t leaf_q[$];
   wr_t query_q[$];
   int  out_q[$];
   wr_t mon_e;

   int errors = 0;
   int checks = 0;
   int n_node = 0, n_leaf = 0, n_query = 0, n_start = 0, n_ren = 0, n_pop = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected value %0d expected none", name, act);
   endtask

   // Result memory model: read data is the address, one cycle later
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) res_rdata <= '0;
      else if (res_ren) res_rdata <= 11'(res_raddr);
   end

   // Monitor: pops the scoreboard whenever the DUT strobes or a word is popped
   always @(negedge clk) begin
      if (rst_n) begin
         if (node_wen) begin
            n_node++;
            if (node_q.size() == 0) unexpected("node_wen", int'(node_waddr));
            else begin
               mon_e = node_q.pop_front();
               chk("node_addr", int'(node_waddr), mon_e.addr);
               chk("node_data", int'(node_wdata), mon_e.data);
            end
         end
         if (leaf_wen) begin
            n_leaf++;
            if (leaf_q.size() == 0) unexpected("leaf_wen", int'(leaf_waddr));
            else begin
               mon_e = leaf_q.pop_front();
               chk("leaf_addr", int'(leaf_waddr), mon_e.addr);
               chk("leaf_data", int'(leaf_wdata), mon_e.data);
            end
         end
         if (query_wen) begin
            n_query++;
            if (query_q.size() == 0) unexpected("query_wen", int'(query_waddr));
            else begin
               mon_e = query_q.pop_front();
               chk("query_addr", int'(query_waddr), mon_e.addr);
               chk("query_data", int'(query_wdata), mon_e.data);
            end
         end
         if (core_start) n_start++;
         if (res_ren) n_ren++;
         if (host.out_rempty_n && host.out_deq) begin
            n_pop++;
            if (out_q.size() == 0) unexpected("out_word", int'(host.out_rdata));
            else chk("out_word", int'(host.out_rdata), out_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int word_of(input int g);
      return (g * 37 + 5) % 2048;
   endfunction

   // Streams words 0..n-1 of a load sequence, pushing the expected writes
   task automatic stream(input int n);
      int prev;
      int w;
      prev = 0;
      for (int g = 0; g < n; g++) begin
         w = word_of(g);
         host.in_wenq  = 1'b1;
         host.in_wdata = 11'(w);
         if (g < NODE_WORDS) begin
            if (g % 2 == 1) node_q.push_back('{g / 2, (prev << 11) | w});
            prev = w;
         end else if (g < NODE_WORDS + LEAF_WORDS) begin
            leaf_q.push_back('{g - NODE_WORDS, w});
         end else begin
            query_q.push_back('{g - NODE_WORDS - LEAF_WORDS, w});
         end
         tick();
      end
      host.in_wenq  = 1'b0;
      host.in_wdata = '0;
   endtask

   task automatic pulse_load();
      host.load_kdtree = 1'b1;
      tick();
      host.load_kdtree = 1'b0;
   endtask

   // Host order: px, x block, row, column within block; ragged last block
   task automatic build_expected();
      for (int px = 0; px < 2; px++)
         for (int x = 0; x < 4; x++)
            for (int y = 0; y < 19; y++)
               for (int xi = 0; xi < 4; xi++)
                  if (x * 4 + xi < 13) out_q.push_back(px * 13 + y * 26 + x * 4 + xi);
   endtask

   // Full load, start and done: leaves the DUT in DONE
   task automatic prepare_done();
      pulse_load();
      stream(TOTAL);
      host.fsm_start = 1'b1;
      tick();
      host.fsm_start = 1'b0;
      tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      tick();
   endtask

   int b_node, b_leaf, b_query, b_start, b_ren, b_pop;
   int lat, run, cyc;

   initial begin
      host.load_kdtree   = 1'b0;
      host.in_wenq       = 1'b0;
      host.in_wdata      = '0;
      host.fsm_start     = 1'b0;
      host.send_best_arr = 1'b0;
      host.out_deq       = 1'b0;
      core_done          = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("reset_out_rempty_n", int'(host.out_rempty_n), 0);
      chk("reset_out_rdata", int'(host.out_rdata), 0);
      chk("reset_fsm_done", int'(host.fsm_done), 0);
      chk("reset_core_start", int'(core_start), 0);
      chk("reset_res_ren", int'(res_ren), 0);
      chk("reset_res_raddr", int'(res_raddr), 0);
      rst_n = 1'b1;
      tick();

      // Ignored events in IDLE
      host.fsm_start = 1'b1;
      tick();
      host.fsm_start = 1'b0;
      host.send_best_arr = 1'b1;
      tick();
      host.send_best_arr = 1'b0;
      host.in_wenq = 1'b1;
      host.in_wdata = 11'h2AA;
      repeat (3) tick();
      host.in_wenq = 1'b0;
      repeat (3) tick();
      chk("idle_no_core_start", n_start, 0);
      chk("idle_no_res_ren", n_ren, 0);
      chk("idle_no_writes", n_node + n_leaf + n_query, 0);

      // Reload mid LD_LEAF, with a word presented in the load cycle
      pulse_load();
      stream(NODE_WORDS + 100);
      host.load_kdtree = 1'b1;
      host.in_wenq     = 1'b1;
      host.in_wdata    = 11'h555;
      tick();
      host.load_kdtree = 1'b0;
      host.in_wenq     = 1'b0;
      stream(4);
      tick();
      chk("reload_node_count", n_node, 63 + 2);
      chk("reload_leaf_count", n_leaf, 100);
      chk("reload_node_q_empty", node_q.size(), 0);

      // Full load
      b_node = n_node; b_leaf = n_leaf; b_query = n_query;
      pulse_load();
      stream(TOTAL);
      tick();
      chk("load_node_count", n_node - b_node, 63);
      chk("load_leaf_count", n_leaf - b_leaf, LEAF_WORDS);
      chk("load_query_count", n_query - b_query, QUERY_WORDS);
      chk("load_queues_empty", node_q.size() + leaf_q.size() + query_q.size(), 0);

      // Ignored events in READY
      b_node = n_node; b_leaf = n_leaf; b_query = n_query; b_ren = n_ren;
      host.in_wenq = 1'b1;
      host.in_wdata = 11'h123;
      repeat (4) tick();
      host.in_wenq = 1'b0;
      host.send_best_arr = 1'b1;
      tick();
      host.send_best_arr = 1'b0;
      repeat (3) tick();
      chk("ready_no_writes", (n_node - b_node) + (n_leaf - b_leaf) + (n_query - b_query), 0);
      chk("ready_no_res_ren", n_ren - b_ren, 0);

      // Start, ignored events in RUN, done
      b_start = n_start;
      host.fsm_start = 1'b1;
      tick();
      host.fsm_start = 1'b0;
      repeat (3) tick();
      chk("core_start_once", n_start - b_start, 1);
      b_ren = n_ren;
      host.fsm_start = 1'b1;
      tick();
      host.fsm_start = 1'b0;
      host.send_best_arr = 1'b1;
      tick();
      host.send_best_arr = 1'b0;
      repeat (3) tick();
      chk("run_no_extra_start", n_start - b_start, 1);
      chk("run_no_res_ren", n_ren - b_ren, 0);
      chk("run_fsm_done_low", int'(host.fsm_done), 0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("fsm_done_next_cycle", int'(host.fsm_done), 1);
      repeat (5) tick();
      chk("fsm_done_sticky", int'(host.fsm_done), 1);

      // Drain with out_deq held high
      build_expected();
      b_pop = n_pop;
      host.out_deq = 1'b1;
      host.send_best_arr = 1'b1;
      tick();
      host.send_best_arr = 1'b0;
      lat = 1;
      while (!host.out_rempty_n && lat < 20) begin
         tick();
         lat++;
      end
      chk("first_word_latency", lat, 3);
      run = 0;
      while (host.out_rempty_n && run < 2000) begin
         tick();
         run++;
      end
      chk("sustained_run_length", run, NQ);
      chk("drain_pop_count", n_pop - b_pop, NQ);
      chk("drain_queue_empty", out_q.size(), 0);
      chk("drain_rempty_n_low", int'(host.out_rempty_n), 0);
      chk("drain_fsm_done_held", int'(host.fsm_done), 1);
      host.out_deq = 1'b0;
      tick();

      // Drain with random backpressure
      prepare_done();
      build_expected();
      b_pop = n_pop;
      host.send_best_arr = 1'b1;
      tick();
      host.send_best_arr = 1'b0;
      cyc = 0;
      while ((n_pop - b_pop) < NQ && cyc < 5000) begin
         host.out_deq = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      host.out_deq = 1'b0;
      chk("bp_no_timeout", int'(cyc < 5000), 1);
      repeat (4) tick();
      chk("bp_pop_count", n_pop - b_pop, NQ);
      chk("bp_queue_empty", out_q.size(), 0);
      chk("bp_rempty_n_low", int'(host.out_rempty_n), 0);

      // Reset in the middle of SEND
      prepare_done();
      build_expected();
      b_pop = n_pop;
      host.out_deq = 1'b1;
      host.send_best_arr = 1'b1;
      tick();
      host.send_best_arr = 1'b0;
      cyc = 0;
      while ((n_pop - b_pop) < 100 && cyc < 1000) begin
         tick();
         cyc++;
      end
      chk("midsend_reached", n_pop - b_pop, 100);
      rst_n = 1'b0;
      host.out_deq = 1'b0;
      #1;
      chk("rst_out_rempty_n", int'(host.out_rempty_n), 0);
      chk("rst_out_rdata", int'(host.out_rdata), 0);
      chk("rst_fsm_done", int'(host.fsm_done), 0);
      chk("rst_res_ren", int'(res_ren), 0);
      chk("rst_res_raddr", int'(res_raddr), 0);
      out_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      b_node = n_node;
      pulse_load();
      stream(4);
      tick();
      chk("post_reset_node_count", n_node - b_node, 2);
      chk("post_reset_node_q_empty", node_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
